// File: rtl/i2c_xfer_sequencer.sv
// Sequences the byte-level I2C core through complete register-write and
// register-read transfers from a single command, with NACK and watchdog status.
module i2c_xfer_sequencer #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       xfer_done,
  output logic [1:0] xfer_status,
  output logic [7:0] rd_data,
  output logic       start_cond,
  output logic       write_byte,
  output logic       pointer,
  output logic       read,
  output logic       stop_cond,
  output logic [7:0] byte_to_write,
  input  logic       start_done,
  input  logic       write_done,
  input  logic       read_done,
  input  logic       stop_done,
  input  logic       ack_w,
  input  logic [7:0] byte_r
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, START, DEVW, REG, WDATA, RSTART, DEVR, RDB, STOP, GAP, DONE
  } state_t;

  state_t          state, state_d;
  state_t          after_gap, after_gap_d;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;
  logic            accept, is_phase, nack_hit, timeout_hit;
  logic            rw_q;
  logic [6:0]      dev_q;
  logic [7:0]      reg_q, wdata_q;
  logic [1:0]      status_q;
  logic [7:0]      rd_q;

  assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign xfer_status = status_q;
  assign rd_data     = rd_q;

  always_comb begin
    state_d       = state;
    after_gap_d   = after_gap;
    accept        = 1'b0;
    is_phase      = 1'b0;
    nack_hit      = 1'b0;
    timeout_hit   = 1'b0;
    cmd_ready     = 1'b0;
    xfer_done     = 1'b0;
    start_cond    = 1'b0;
    write_byte    = 1'b0;
    pointer       = 1'b0;
    read          = 1'b0;
    stop_cond     = 1'b0;
    byte_to_write = 8'h00;
    case (state)
      IDLE: begin
        cmd_ready = ~reset;
        accept    = cmd_valid & ~reset;
        if (accept) state_d = START;
      end
      START, RSTART: begin
        is_phase   = 1'b1;
        start_cond = 1'b1;
        if (start_done) begin
          state_d     = GAP;
          after_gap_d = (state == START) ? DEVW : DEVR;
        end
      end
      DEVW, REG, WDATA, DEVR: begin
        is_phase   = 1'b1;
        write_byte = 1'b1;
        pointer    = (state == DEVW) || (state == DEVR);
        case (state)
          DEVW:    byte_to_write = {dev_q, 1'b0};
          REG:     byte_to_write = reg_q;
          WDATA:   byte_to_write = wdata_q;
          default: byte_to_write = {dev_q, 1'b1};
        endcase
        if (write_done) begin
          state_d = GAP;
          if (ack_w) begin
            nack_hit    = 1'b1;
            after_gap_d = STOP;
          end else begin
            case (state)
              DEVW:    after_gap_d = REG;
              REG:     after_gap_d = rw_q ? RSTART : WDATA;
              WDATA:   after_gap_d = STOP;
              default: after_gap_d = RDB;
            endcase
          end
        end
      end
      RDB: begin
        is_phase = 1'b1;
        read     = 1'b1;
        if (read_done) begin
          state_d     = GAP;
          after_gap_d = STOP;
        end
      end
      STOP: begin
        is_phase  = 1'b1;
        stop_cond = 1'b1;
        if (stop_done) state_d = DONE;
      end
      GAP:     state_d = after_gap;
      DONE: begin
        xfer_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A completion arriving on the last watchdog cycle still wins.
    if (is_phase && (state_d == state) && wd_expired) begin
      state_d     = DONE;
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      after_gap <= IDLE;
      wd_cnt    <= '0;
      status_q  <= 2'b00;
      rd_q      <= 8'h00;
    end else begin
      state     <= state_d;
      after_gap <= after_gap_d;
      wd_cnt    <= (is_phase && (state_d == state)) ? wd_cnt + 1'b1 : '0;
      if (accept)           status_q <= 2'b00;
      else if (timeout_hit) status_q <= 2'b10;
      else if (nack_hit)    status_q <= 2'b01;
      if ((state == RDB) && read_done) rd_q <= byte_r;
    end
  end

  // Command fields are only sampled on accept; they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rw_q    <= cmd_rw;
      dev_q   <= cmd_dev;
      reg_q   <= cmd_reg;
      wdata_q <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Scoreboard bench for i2c_xfer_sequencer: a behavioural I2C core logs every
// served request, and each scenario task checks the logged bus events and results.
module tb_i2c_xfer_sequencer;

  localparam int TO     = 16;
  localparam int EV_W   = 32'h100;
  localparam int EV_PTR = 32'h200;
  localparam int EV_S   = 32'h400;
  localparam int EV_P   = 32'h800;
  localparam int EV_R   = 32'h1000;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       xfer_done;
  logic [1:0] xfer_status;
  logic [7:0] rd_data;
  logic       start_cond, write_byte, pointer, read, stop_cond;
  logic [7:0] byte_to_write;
  logic       start_done, write_done, read_done, stop_done, ack_w;
  logic [7:0] byte_r;

  always #5 clk = ~clk;

  i2c_xfer_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .xfer_done(xfer_done), .xfer_status(xfer_status), .rd_data(rd_data),
    .start_cond(start_cond), .write_byte(write_byte), .pointer(pointer),
    .read(read), .stop_cond(stop_cond), .byte_to_write(byte_to_write),
    .start_done(start_done), .write_done(write_done), .read_done(read_done),
    .stop_done(stop_done), .ack_w(ack_w), .byte_r(byte_r)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         lat = 0;
  logic       never_start = 1'b0;
  int         nack_byte = -1;
  logic [7:0] rd_val = 8'h00;
  int         obs_log[$];
  int         gap_viol = 0;
  int         obs_ptr = 0;
  int         exp_ev[$];
  logic [9:0] exp_res[$];
  logic [7:0] exp_rd = 8'h00;

  // Behavioural core: answers each request after lat extra cycles.
  initial begin : core_model
    int   age;
    int   ev;
    logic pulsed;
    age = 0; pulsed = 1'b0;
    start_done = 0; write_done = 0; read_done = 0; stop_done = 0;
    ack_w = 0; byte_r = 8'h00;
    forever begin
      @(negedge clk);
      start_done = 0; write_done = 0; read_done = 0; stop_done = 0; ack_w = 0;
      if (pulsed && (start_cond | write_byte | read | stop_cond)) gap_viol++;
      pulsed = 1'b0;
      if (reset || !(start_cond | write_byte | read | stop_cond)) begin
        age = 0;
      end else begin
        age++;
        if (age > lat && !(start_cond && never_start)) begin
          ev = 0;
          if (start_cond) ev |= EV_S;
          if (stop_cond)  ev |= EV_P;
          if (read)       ev |= EV_R;
          if (write_byte) ev |= EV_W | int'(byte_to_write);
          if (pointer)    ev |= EV_PTR;
          obs_log.push_back(ev);
          start_done = start_cond;
          write_done = write_byte;
          read_done  = read;
          stop_done  = stop_cond;
          ack_w      = write_byte && (int'(byte_to_write) == nack_byte);
          byte_r     = rd_val;
          pulsed     = 1'b1;
          age        = 0;
        end
      end
    end
  end

  function automatic int next_obs();
    int v;
    if (obs_ptr < obs_log.size()) begin
      v = obs_log[obs_ptr];
      obs_ptr++;
    end else begin
      v = -1;
    end
    return v;
  endfunction

  function automatic void push_write(input logic [6:0] dev, input logic [7:0] rg,
                                     input logic [7:0] wd);
    exp_ev.push_back(EV_S);
    exp_ev.push_back(EV_W | EV_PTR | int'({dev, 1'b0}));
    exp_ev.push_back(EV_W | int'(rg));
    exp_ev.push_back(EV_W | int'(wd));
    exp_ev.push_back(EV_P);
  endfunction

  function automatic void push_read(input logic [6:0] dev, input logic [7:0] rg);
    exp_ev.push_back(EV_S);
    exp_ev.push_back(EV_W | EV_PTR | int'({dev, 1'b0}));
    exp_ev.push_back(EV_W | int'(rg));
    exp_ev.push_back(EV_S);
    exp_ev.push_back(EV_W | EV_PTR | int'({dev, 1'b1}));
    exp_ev.push_back(EV_R);
    exp_ev.push_back(EV_P);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, output bit ok);
    int n;
    n = 0;
    cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = (n < 200);
  endtask

  task automatic wait_done(output bit ok, output int cyc);
    ok = 0; cyc = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (xfer_done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0;
    cmd_dev = 7'h00; cmd_reg = 8'h00; cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0", cmd_ready);
    end
    vectors++;
    if ({start_cond, write_byte, pointer, read, stop_cond, xfer_done} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_reqs: got %b want 000000",
               {start_cond, write_byte, pointer, read, stop_cond, xfer_done});
    end
    vectors++;
    if ({xfer_status, rd_data, byte_to_write} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_data: status %b rd %h byte %h want 0", xfer_status, rd_data, byte_to_write);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL post_reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_write();
    bit ok; int cyc; int e; int o; logic [9:0] r;
    lat = 0;
    push_write(7'h48, 8'h01, 8'hA5);
    exp_res.push_back({2'b00, exp_rd});
    issue(1'b0, 7'h48, 8'h01, 8'hA5, ok);
    wait_done(ok, cyc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL write_done: no xfer_done"); end
    // START cycle is the first after accept; GAP after every phase but STOP.
    vectors++;
    if (cyc + 1 !== 10) begin
      miscompares++; $display("FAIL write_latency: got %0d cycles want 10", cyc + 1);
    end
    r = exp_res.pop_front();
    vectors++;
    if (xfer_status !== r[9:8]) begin
      miscompares++; $display("FAIL write_status: got %b want %b", xfer_status, r[9:8]);
    end
    vectors++;
    if (rd_data !== r[7:0]) begin
      miscompares++; $display("FAIL write_rd: got %h want %h", rd_data, r[7:0]);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL write_ev: got %h want %h", o, e); end
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL write_ready_back: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_read();
    bit ok; int cyc; int e; int o; logic [9:0] r;
    lat = 2; rd_val = 8'h3C; exp_rd = 8'h3C;
    push_read(7'h48, 8'h00);
    exp_res.push_back({2'b00, exp_rd});
    issue(1'b1, 7'h48, 8'h00, 8'hEE, ok);
    wait_done(ok, cyc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL read_done: no xfer_done"); end
    r = exp_res.pop_front();
    vectors++;
    if ({xfer_status, rd_data} !== r) begin
      miscompares++; $display("FAIL read_result: got %b/%h want %b/%h", xfer_status, rd_data, r[9:8], r[7:0]);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL read_ev: got %h want %h", o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_nack();
    bit ok; int cyc; int e; int o; logic [9:0] r;
    lat = 1; nack_byte = 8'h10;
    exp_ev.push_back(EV_S);
    exp_ev.push_back(EV_W | EV_PTR | 32'h90);
    exp_ev.push_back(EV_W | 32'h10);
    exp_ev.push_back(EV_P);
    exp_res.push_back({2'b01, exp_rd});
    issue(1'b0, 7'h48, 8'h10, 8'h77, ok);
    wait_done(ok, cyc);
    nack_byte = -1;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL nack_done: no xfer_done"); end
    r = exp_res.pop_front();
    vectors++;
    if (xfer_status !== r[9:8]) begin
      miscompares++; $display("FAIL nack_status: got %b want %b", xfer_status, r[9:8]);
    end
    vectors++;
    if (rd_data !== r[7:0]) begin
      miscompares++; $display("FAIL nack_rd: got %h want %h", rd_data, r[7:0]);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL nack_ev: got %h want %h", o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit ok; int hi; int stops; int n; logic [9:0] r;
    never_start = 1'b1; lat = 0;
    exp_res.push_back({2'b10, exp_rd});
    issue(1'b0, 7'h48, 8'h01, 8'h02, ok);
    hi = start_cond ? 1 : 0; stops = 0; n = 0; ok = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (start_cond) hi++;
      if (stop_cond) stops++;
      if (xfer_done) begin ok = 1; break; end
    end
    never_start = 1'b0;
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL timeout_done: no xfer_done"); end
    vectors++;
    if (hi !== TO) begin
      miscompares++; $display("FAIL timeout_len: start_cond high %0d cycles want %0d", hi, TO);
    end
    vectors++;
    if (stops !== 0) begin
      miscompares++; $display("FAIL timeout_stop: got %0d stop cycles want 0", stops);
    end
    r = exp_res.pop_front();
    vectors++;
    if ({xfer_status, rd_data} !== r) begin
      miscompares++; $display("FAIL timeout_result: got %b/%h want %b/%h", xfer_status, rd_data, r[9:8], r[7:0]);
    end
    vectors++;
    if (obs_ptr !== obs_log.size()) begin
      miscompares++; $display("FAIL timeout_ev: got %0d served requests want 0", obs_log.size() - obs_ptr);
    end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL timeout_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int n; int busy_ready; int cyc; int e; int o; logic [9:0] r;
    lat = 1; rd_val = 8'hC3;
    cmd_rw = 1'b0; cmd_dev = 7'h22; cmd_reg = 8'h05; cmd_wdata = 8'h5A; cmd_valid = 1'b1;
    push_write(7'h22, 8'h05, 8'h5A);
    exp_res.push_back({2'b00, exp_rd});
    @(negedge clk);
    cmd_rw = 1'b1; cmd_dev = 7'h33; cmd_reg = 8'h07; cmd_wdata = 8'h00;
    busy_ready = 0; n = 0; ok = 0;
    while (n < 200) begin
      if (xfer_done) begin ok = 1; break; end
      if (cmd_ready) busy_ready++;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_first_done: no xfer_done"); end
    vectors++;
    if (busy_ready !== 0) begin
      miscompares++; $display("FAIL b2b_busy_ready: cmd_ready high %0d cycles want 0", busy_ready);
    end
    r = exp_res.pop_front();
    vectors++;
    if ({xfer_status, rd_data} !== r) begin
      miscompares++; $display("FAIL b2b_first_result: got %b/%h want %b/%h", xfer_status, rd_data, r[9:8], r[7:0]);
    end
    exp_rd = 8'hC3;
    push_read(7'h33, 8'h07);
    exp_res.push_back({2'b00, exp_rd});
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_ready_after_done: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if (start_cond !== 1'b1) begin
      miscompares++; $display("FAIL b2b_second_start: got %b want 1", start_cond);
    end
    wait_done(ok, cyc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL b2b_second_done: no xfer_done"); end
    r = exp_res.pop_front();
    vectors++;
    if ({xfer_status, rd_data} !== r) begin
      miscompares++; $display("FAIL b2b_second_result: got %b/%h want %b/%h", xfer_status, rd_data, r[9:8], r[7:0]);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL b2b_ev: got %h want %h", o, e); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok; int n; int cyc; int e; int o; logic [9:0] r;
    lat = 3;
    exp_ev.push_back(EV_S);
    exp_ev.push_back(EV_W | EV_PTR | 32'hA0);
    issue(1'b0, 7'h50, 8'h66, 8'h99, ok);
    n = 0;
    while (!(write_byte && byte_to_write == 8'h66) && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 100) begin miscompares++; $display("FAIL mid_reach_reg: REG phase never seen"); end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({start_cond, write_byte, pointer, read, stop_cond} !== 5'b0) begin
      miscompares++;
      $display("FAIL mid_reqs: got %b want 00000", {start_cond, write_byte, pointer, read, stop_cond});
    end
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++; $display("FAIL mid_ready_in_reset: got %b want 0", cmd_ready);
    end
    reset = 1'b0;
    exp_rd = 8'h00;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, rd_data, xfer_status} !== {1'b1, exp_rd, 2'b00}) begin
      miscompares++; $display("FAIL mid_after_reset: ready %b rd %h status %b want 1/%h/00", cmd_ready, rd_data, xfer_status, exp_rd);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mid_ev: got %h want %h", o, e); end
    end
    vectors++;
    if (obs_ptr !== obs_log.size()) begin
      miscompares++; $display("FAIL mid_extra_ev: %0d unexpected served requests", obs_log.size() - obs_ptr);
    end
    lat = 0;
    push_write(7'h48, 8'h02, 8'h11);
    exp_res.push_back({2'b00, exp_rd});
    issue(1'b0, 7'h48, 8'h02, 8'h11, ok);
    wait_done(ok, cyc);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL mid_fresh_done: no xfer_done"); end
    r = exp_res.pop_front();
    vectors++;
    if ({xfer_status, rd_data} !== r) begin
      miscompares++; $display("FAIL mid_fresh_result: got %b/%h want %b/%h", xfer_status, rd_data, r[9:8], r[7:0]);
    end
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front(); o = next_obs(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mid_fresh_ev: got %h want %h", o, e); end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    vectors++;
    if (gap_viol !== 0) begin
      miscompares++; $display("FAIL gap: %0d requests not released after done, want 0", gap_viol);
    end
    vectors++;
    if (obs_ptr !== obs_log.size()) begin
      miscompares++; $display("FAIL trailing_ev: %0d unexpected served requests", obs_log.size() - obs_ptr);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
